// File: rtl/frame_bank_sched_if.sv
// Purpose: bundles the frame_bank_sched loader/scan-out pulses and status outputs.
// Latency: none; this interface holds wiring only.
// Backpressure: none; every signal is a pulse or a level, with no handshake.
// Ports: master drives frame_start/frame_done/frame_abort/vsync_n and observes status;
//        slave (the scheduler) observes the pulses and drives rd_bank, wr_bank, wr_gate,
//        frame_pending, swap_pulse, flash_phase, overrun_cnt, abort_cnt.
interface frame_bank_sched_if #(
    parameter int CNT_W = 8
);
    logic             frame_start;
    logic             frame_done;
    logic             frame_abort;
    logic             vsync_n;
    logic             rd_bank;
    logic             wr_bank;
    logic             wr_gate;
    logic             frame_pending;
    logic             swap_pulse;
    logic             flash_phase;
    logic [CNT_W-1:0] overrun_cnt;
    logic [CNT_W-1:0] abort_cnt;

    modport master (
        output frame_start, frame_done, frame_abort, vsync_n,
        input  rd_bank, wr_bank, wr_gate, frame_pending, swap_pulse, flash_phase,
               overrun_cnt, abort_cnt
    );

    modport slave (
        input  frame_start, frame_done, frame_abort, vsync_n,
        output rd_bank, wr_bank, wr_gate, frame_pending, swap_pulse, flash_phase,
               overrun_cnt, abort_cnt
    );
endinterface

// File: rtl/frame_bank_sched.sv
// Purpose: double-buffer bank scheduler; swaps a completed frame to scan-out at vsync start.
// Latency: outputs registered; 1 cycle after the input pulse, swap_pulse 1 cycle after rd_bank.
// Backpressure: none; a frame arriving while one is pending is dropped and counted.
// Ports: PixelClk (only clock), nRST (sync, active-low), bus (frame_bank_sched_if.slave):
//        frame_start/frame_done/frame_abort pulses and vsync_n level in; bank selects,
//        wr_gate, frame_pending, swap_pulse, flash_phase and saturating drop counters out.
// Build option: FRAME_SCHED_WDOG_EN adds a FILL watchdog (WDOG_FRAMES vsync starts).
module frame_bank_sched #(
    parameter int FLASH_BITS  = 5,
    parameter int CNT_W       = 8
`ifdef FRAME_SCHED_WDOG_EN
   ,parameter int WDOG_FRAMES = 4
`endif
) (
    input  logic              PixelClk,
    input  logic              nRST,
    frame_bank_sched_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_PEND,
        ST_DROP
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  vsync_q;
    logic                  vs_evt;
    logic                  do_swap;
    logic                  ovr_inc;
    logic                  abt_inc;
    logic                  rd_bank_q;
    logic                  wr_bank_q;
    logic                  wr_gate_q;
    logic                  pend_q;
    logic                  swap_req_q;
    logic                  swap_pulse_q;
    logic [FLASH_BITS-1:0] flash_q;
    logic [CNT_W-1:0]      ovr_q;
    logic [CNT_W-1:0]      abt_q;

    // vsync start: first cycle vsync_n is seen low after being high.
    assign vs_evt = vsync_q & ~bus.vsync_n;

`ifdef FRAME_SCHED_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_FRAMES + 1);
    logic [WDOG_W-1:0] wdog_q;
    logic              wdog_last;

    assign wdog_last = (wdog_q == WDOG_W'(WDOG_FRAMES - 1));

    // Counts vsync starts seen while filling; cleared on every entry or restart of FILL.
    always_ff @(posedge PixelClk) begin
        if (!nRST) begin
            wdog_q <= '0;
        end else if (state_d == ST_FILL && (state_q != ST_FILL || bus.frame_start)) begin
            wdog_q <= '0;
        end else if (state_q == ST_FILL && state_d == ST_FILL && vs_evt) begin
            wdog_q <= wdog_q + 1'b1;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        do_swap = 1'b0;
        ovr_inc = 1'b0;
        abt_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.frame_start) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                // frame_done outranks a coincident abort or vsync; no swap until the next vsync.
                if (bus.frame_done) begin
                    state_d = ST_PEND;
                end else if (bus.frame_abort) begin
                    state_d = ST_IDLE;
                    abt_inc = 1'b1;
                end else if (bus.frame_start) begin
                    state_d = ST_FILL;  // restart; loader rewrites the same bank
`ifdef FRAME_SCHED_WDOG_EN
                end else if (vs_evt && wdog_last) begin
                    state_d = ST_IDLE;
                    abt_inc = 1'b1;
`endif
                end
            end
            ST_PEND: begin
                // A coincident frame_start is accepted into the freshly freed bank.
                if (vs_evt) begin
                    do_swap = 1'b1;
                    state_d = bus.frame_start ? ST_FILL : ST_IDLE;
                end else if (bus.frame_start) begin
                    state_d = ST_DROP;
                    ovr_inc = 1'b1;
                end
            end
            ST_DROP: begin
                // The discarded transfer keeps running unwritten; only vsync matters here.
                if (vs_evt) begin
                    do_swap = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PixelClk) begin
        if (!nRST) begin
            state_q      <= ST_IDLE;
            vsync_q      <= 1'b1;
            rd_bank_q    <= 1'b0;
            wr_bank_q    <= 1'b1;
            wr_gate_q    <= 1'b0;
            pend_q       <= 1'b0;
            swap_req_q   <= 1'b0;
            swap_pulse_q <= 1'b0;
            flash_q      <= '0;
            ovr_q        <= '0;
            abt_q        <= '0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= bus.vsync_n;
            wr_gate_q    <= (state_d == ST_FILL);
            pend_q       <= (state_d == ST_PEND) || (state_d == ST_DROP);
            swap_req_q   <= do_swap;
            swap_pulse_q <= swap_req_q;
            if (do_swap) begin
                rd_bank_q <= ~rd_bank_q;
                wr_bank_q <= ~wr_bank_q;
            end
            if (vs_evt) begin
                flash_q <= flash_q + 1'b1;
            end
            if (ovr_inc && ovr_q != '1) begin
                ovr_q <= ovr_q + 1'b1;
            end
            if (abt_inc && abt_q != '1) begin
                abt_q <= abt_q + 1'b1;
            end
        end
    end

    assign bus.rd_bank       = rd_bank_q;
    assign bus.wr_bank       = wr_bank_q;
    assign bus.wr_gate       = wr_gate_q;
    assign bus.frame_pending = pend_q;
    assign bus.swap_pulse    = swap_pulse_q;
    assign bus.flash_phase   = flash_q[FLASH_BITS-1];
    assign bus.overrun_cnt   = ovr_q;
    assign bus.abort_cnt     = abt_q;

endmodule

// File: tb/tb_frame_bank_sched.sv
// Purpose: self-checking bench for frame_bank_sched (vector table, directed corners, random vs model).
// Latency: inputs driven on the falling edge, outputs compared on the next falling edge.
// Backpressure: not applicable.
module tb_frame_bank_sched;
    localparam int FLASH_BITS  = 5;
    localparam int CNT_W       = 8;
    localparam int WDOG_FRAMES = 4;
`ifdef FRAME_SCHED_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    logic PixelClk = 1'b0;
    logic nRST     = 1'b0;
    always #5 PixelClk = ~PixelClk;

    frame_bank_sched_if #(.CNT_W(CNT_W)) bus ();

    frame_bank_sched #(
        .FLASH_BITS (FLASH_BITS),
        .CNT_W      (CNT_W)
`ifdef FRAME_SCHED_WDOG_EN
       ,.WDOG_FRAMES(WDOG_FRAMES)
`endif
    ) dut (
        .PixelClk (PixelClk),
        .nRST     (nRST),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a frame slot being filled, a finished frame waiting (optionally
    // with an incoming frame being thrown away), and plain counters.
    bit m_filling   = 0;
    bit m_waiting   = 0;
    bit m_discard   = 0;
    bit m_rd        = 0;
    bit m_swap_due  = 0;
    bit m_swap_out  = 0;
    bit m_vs_prev   = 1;
    int m_flash     = 0;
    int m_overruns  = 0;
    int m_aborts    = 0;
    int m_vs_filled = 0;

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    task automatic model_clk(input bit rst_n, input bit fs, input bit fd, input bit fa, input bit vsn);
        bit vsync_start;
        if (!rst_n) begin
            m_filling = 0; m_waiting = 0; m_discard = 0; m_rd = 0;
            m_swap_due = 0; m_swap_out = 0; m_vs_prev = 1;
            m_flash = 0; m_overruns = 0; m_aborts = 0; m_vs_filled = 0;
            return;
        end
        vsync_start = m_vs_prev && !vsn;
        m_vs_prev   = vsn;
        m_swap_out  = m_swap_due;
        m_swap_due  = 0;
        if (vsync_start) m_flash = (m_flash + 1) % (1 << FLASH_BITS);
        if (m_filling) begin
            if (fd) begin
                m_filling = 0; m_waiting = 1;
            end else if (fa) begin
                m_filling = 0;
                if (m_aborts < CNT_MAX) m_aborts++;
            end else if (fs) begin
                m_vs_filled = 0;
            end else if (vsync_start) begin
                m_vs_filled++;
                if (WDOG_ON && m_vs_filled == WDOG_FRAMES) begin
                    m_filling = 0;
                    if (m_aborts < CNT_MAX) m_aborts++;
                end
            end
        end else if (m_waiting || m_discard) begin
            if (vsync_start) begin
                m_rd = !m_rd;
                m_swap_due = 1;
                m_filling = m_waiting && fs;
                m_vs_filled = 0;
                m_waiting = 0;
                m_discard = 0;
            end else if (m_waiting && fs) begin
                m_waiting = 0;
                m_discard = 1;
                if (m_overruns < CNT_MAX) m_overruns++;
            end
        end else if (fs) begin
            m_filling = 1;
            m_vs_filled = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("model_rd_bank",       bus.rd_bank,       m_rd);
        chk("model_wr_bank",       bus.wr_bank,       !m_rd);
        chk("model_wr_gate",       bus.wr_gate,       m_filling);
        chk("model_frame_pending", bus.frame_pending, m_waiting || m_discard);
        chk("model_swap_pulse",    bus.swap_pulse,    m_swap_out);
        chk("model_flash_phase",   bus.flash_phase,   m_flash >= (1 << (FLASH_BITS - 1)));
        chk("model_overrun_cnt",   bus.overrun_cnt,   m_overruns);
        chk("model_abort_cnt",     bus.abort_cnt,     m_aborts);
    endtask

    // One clock: drive inputs, let the edge pass, update the model, compare at the falling edge.
    task automatic step(input bit fs, input bit fd, input bit fa, input bit vsn);
        bus.frame_start = fs;
        bus.frame_done  = fd;
        bus.frame_abort = fa;
        bus.vsync_n     = vsn;
        @(posedge PixelClk);
        model_clk(nRST, fs, fd, fa, vsn);
        @(negedge PixelClk);
        bus.frame_start = 1'b0;
        bus.frame_done  = 1'b0;
        bus.frame_abort = 1'b0;
        cmp_model();
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        nRST = 1'b1;
    endtask

    typedef struct {
        bit fs, fd, fa, vsn;
        bit gate, pend, rd, swp;
    } vec_t;

    initial begin
        vec_t tbl[7];
        tbl[0] = '{1, 0, 0, 1,  1, 0, 0, 0};
        tbl[1] = '{0, 0, 0, 1,  1, 0, 0, 0};
        tbl[2] = '{0, 1, 0, 1,  0, 1, 0, 0};
        tbl[3] = '{0, 0, 0, 1,  0, 1, 0, 0};
        tbl[4] = '{0, 0, 0, 0,  0, 0, 1, 0};
        tbl[5] = '{0, 0, 0, 0,  0, 0, 1, 1};
        tbl[6] = '{0, 0, 0, 1,  0, 0, 1, 0};

        bus.frame_start = 1'b0;
        bus.frame_done  = 1'b0;
        bus.frame_abort = 1'b0;
        bus.vsync_n     = 1'b1;
        @(negedge PixelClk);
        do_reset();

        chk("rst_rd_bank",       bus.rd_bank,       0);
        chk("rst_wr_bank",       bus.wr_bank,       1);
        chk("rst_wr_gate",       bus.wr_gate,       0);
        chk("rst_frame_pending", bus.frame_pending, 0);
        chk("rst_swap_pulse",    bus.swap_pulse,    0);
        chk("rst_flash_phase",   bus.flash_phase,   0);
        chk("rst_overrun_cnt",   bus.overrun_cnt,   0);
        chk("rst_abort_cnt",     bus.abort_cnt,     0);

        // Basic frame then vsync swap.
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].fs, tbl[i].fd, tbl[i].fa, tbl[i].vsn);
            chk($sformatf("vec%0d_wr_gate", i),       bus.wr_gate,       tbl[i].gate);
            chk($sformatf("vec%0d_frame_pending", i), bus.frame_pending, tbl[i].pend);
            chk($sformatf("vec%0d_rd_bank", i),       bus.rd_bank,       tbl[i].rd);
            chk($sformatf("vec%0d_swap_pulse", i),    bus.swap_pulse,    tbl[i].swp);
        end
        chk("vec_wr_bank_after_swap", bus.wr_bank, 0);

        // Second frame while one is pending: dropped, counted, single swap at vsync.
        step(1, 0, 0, 1);
        step(0, 1, 0, 1);
        step(1, 0, 0, 1);
        chk("drop_pending", bus.frame_pending, 1);
        chk("drop_wr_gate", bus.wr_gate, 0);
        chk("drop_overrun", bus.overrun_cnt, 1);
        step(0, 1, 0, 1);
        step(0, 0, 1, 1);
        chk("drop_ignore_pending", bus.frame_pending, 1);
        chk("drop_ignore_abort", bus.abort_cnt, 0);
        step(0, 0, 0, 0);
        chk("drop_swap_rd", bus.rd_bank, 0);
        chk("drop_swap_idle_pending", bus.frame_pending, 0);
        step(0, 0, 0, 0);
        chk("drop_swap_pulse", bus.swap_pulse, 1);
        step(0, 0, 0, 1);
        chk("drop_swap_pulse_end", bus.swap_pulse, 0);
        chk("drop_idle_gate", bus.wr_gate, 0);

        // frame_done coincident with vsync start: swap deferred to the next vsync.
        step(1, 0, 0, 1);
        step(0, 1, 0, 0);
        chk("coinc_pending", bus.frame_pending, 1);
        chk("coinc_no_swap", bus.rd_bank, 0);
        step(0, 0, 0, 0);
        chk("coinc_no_pulse", bus.swap_pulse, 0);
        step(0, 0, 0, 1);
        chk("coinc_still_pending", bus.frame_pending, 1);
        step(0, 0, 0, 0);
        chk("coinc_late_swap", bus.rd_bank, 1);
        step(0, 0, 0, 1);
        chk("coinc_late_pulse", bus.swap_pulse, 1);

        // Abort mid-FILL, then saturate the abort counter.
        step(1, 0, 0, 1);
        step(0, 0, 1, 1);
        chk("abort_gate", bus.wr_gate, 0);
        chk("abort_pending", bus.frame_pending, 0);
        chk("abort_cnt1", bus.abort_cnt, 1);
        chk("abort_rd_kept", bus.rd_bank, 1);
        for (int i = 0; i < 254; i++) begin
            step(1, 0, 0, 1);
            step(0, 0, 1, 1);
        end
        chk("abort_cnt255", bus.abort_cnt, 255);
        step(1, 0, 0, 1);
        step(0, 0, 1, 1);
        chk("abort_saturated", bus.abort_cnt, 255);

        // Reset mid-FILL and mid-PEND: everything back to reset values, pending frame lost.
        step(1, 0, 0, 1);
        do_reset();
        chk("rst_fill_gate", bus.wr_gate, 0);
        chk("rst_fill_abort", bus.abort_cnt, 0);
        chk("rst_fill_overrun", bus.overrun_cnt, 0);
        step(1, 0, 0, 1);
        step(0, 1, 0, 1);
        do_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("rst_pend_no_swap", bus.rd_bank, 0);
        chk("rst_pend_pending", bus.frame_pending, 0);

        // Flash phase over 32 vsync starts with no frames.
        do_reset();
        for (int i = 1; i <= 32; i++) begin
            step(0, 0, 0, 0);
            chk($sformatf("flash_evt%0d", i), bus.flash_phase, ((i % 32) >= 16) ? 1 : 0);
            step(0, 0, 0, 1);
        end
        chk("flash_rd_unchanged", bus.rd_bank, 0);

        // Watchdog: four vsync starts in FILL without frame_done.
        do_reset();
        step(1, 0, 0, 1);
        for (int k = 1; k <= 4; k++) begin
            step(0, 0, 0, 0);
            if (k == 3) chk("wdog_gate_before", bus.wr_gate, 1);
            step(0, 0, 0, 1);
        end
        chk("wdog_gate_after", bus.wr_gate, WDOG_ON ? 0 : 1);
        chk("wdog_abort_cnt", bus.abort_cnt, WDOG_ON ? 1 : 0);

        // Random traffic against the model, with occasional resets.
        do_reset();
        begin
            bit vs_lvl;
            vs_lvl = 1'b1;
            for (int n = 0; n < 4000; n++) begin
                if ($urandom_range(7) == 0) vs_lvl = !vs_lvl;
                nRST = ($urandom_range(299) != 0);
                step($urandom_range(11) == 0, $urandom_range(9) == 0,
                     $urandom_range(24) == 0, vs_lvl);
            end
            nRST = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
